// File: rtl/osd_vram_bus_rx.sv
// osd_vram_bus_rx
// CPU-side command receiver for the OSD character VRAM. It decodes the 16-bit PIO
// command word, which uses a toggle strobe, and queues each transaction in a
// 4-entry FIFO. It executes SETADDR / WRITE / SETCNT / FILL and drives the
// character generator's VRAM write port.
// Ports:
//   CK_i, RST_i        clock, async active-high reset
//   CMD_i[15:0]        [15] cpu_use, [14] strobe toggle, [13:12] op, [11] flag,
//                      [9:0] addr/count, [7:0] data
//   VBLANK_i           vertical blanking level (write gate when C_VBLANK_ONLY=1)
//   VRAM_WAs_o/WDs_o   registered write address/data, hold when WE=0
//   VRAM_WE_o          one clock per written word
//   OSD_CPU_USE_o      registered CMD_i[15]
//   STS_o              {busy, overflow, level[2:0], gate_wait, addr[9:0]}
module osd_vram_bus_rx #(
  parameter bit C_VBLANK_ONLY = 1'b0,
  parameter int C_FIFO_DEPTH  = 4
) (
  input  logic        CK_i,
  input  logic        RST_i,
  input  logic [15:0] CMD_i,
  input  logic        VBLANK_i,
  output logic [9:0]  VRAM_WAs_o,
  output logic [7:0]  VRAM_WDs_o,
  output logic        VRAM_WE_o,
  output logic        OSD_CPU_USE_o,
  output logic [15:0] STS_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FILL, S_WAIT} state_t;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_SETCNT  = 2'b11;

  // entry = {op[1:0], flag, arg[9:0]}
  logic [15:0] cmd_q, cmd_d;
  logic        strb_prev_q, strb_prev_d;
  logic        primed_q, primed_d;
  logic [12:0] fifo_q [C_FIFO_DEPTH];
  logic [12:0] fifo_d [C_FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic        ovf_q, ovf_d;
  state_t      state_q, state_d;
  logic [12:0] cur_q, cur_d;
  logic [9:0]  addr_q, addr_d, cnt_q, cnt_d;
  logic [10:0] rem_q, rem_d;
  logic [9:0]  wa_q, wa_d;
  logic [7:0]  wd_q, wd_d;
  logic        we_q, we_d;

  logic        xact, pop, push_ok, drop, ovf_clr, gated, emit, wr_now;
  logic [10:0] rem, cnt_eff;
  logic        unused_bits;

  assign unused_bits = cmd_q[10];

  // Input stage. While unprimed the previous-strobe register takes the value
  // being loaded into cmd_q, so a strobe level held across reset is not an edge.
  always_comb begin
    cmd_d       = CMD_i;
    primed_d    = 1'b1;
    strb_prev_d = primed_q ? cmd_q[14] : CMD_i[14];
    xact        = primed_q & (cmd_q[14] ^ strb_prev_q);
  end

  // Command FIFO. A push into a full FIFO is still accepted when the head is
  // popped in the same cycle.
  always_comb begin
    pop      = (state_q == S_IDLE) && (level_q != 3'd0);
    push_ok  = xact && ((level_q < 3'(C_FIFO_DEPTH)) || pop);
    drop     = xact && !push_ok;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = {cmd_q[13:12], cmd_q[11], cmd_q[9:0]};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    level_d = level_q + {2'b0, push_ok} - {2'b0, pop};
  end

  // Executor. WRITE is treated as a one-word fill; rem counts words still to
  // emit including the current one.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    ovf_clr = 1'b0;
    emit    = 1'b0;
    wr_now  = 1'b0;
    rem     = rem_q;
    gated   = C_VBLANK_ONLY && !VBLANK_i;
    cnt_eff = (cnt_q == 10'd0) ? 11'd1024 : {1'b0, cnt_q};
    unique case (state_q)
      S_IDLE: if (pop) begin
        cur_d   = fifo_q[rd_ptr_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (cur_q[12:11])
          OP_SETADDR: begin
            addr_d  = cur_q[9:0];
            ovf_clr = cur_q[10];
            state_d = S_IDLE;
          end
          OP_SETCNT: begin
            cnt_d   = cur_q[9:0];
            state_d = S_IDLE;
          end
          default: begin
            rem    = (cur_q[12:11] == OP_WRITE) ? 11'd1 : cnt_eff;
            emit   = 1'b1;
            wr_now = !gated;
          end
        endcase
      end
      S_FILL: begin
        emit   = 1'b1;
        wr_now = !gated;
      end
      S_WAIT: begin
        emit   = 1'b1;
        wr_now = VBLANK_i;
      end
      default: state_d = S_IDLE;
    endcase
    if (emit) begin
      if (wr_now) begin
        we_d    = 1'b1;
        wa_d    = addr_q;
        wd_d    = cur_q[7:0];
        addr_d  = addr_q + 10'd1;
        rem_d   = rem - 11'd1;
        state_d = (rem == 11'd1) ? S_IDLE : S_FILL;
      end else begin
        rem_d   = rem;
        state_d = S_WAIT;
      end
    end
    // A drop in the same cycle as a clear leaves overflow set.
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge CK_i or posedge RST_i) begin
    if (RST_i) begin
      cmd_q       <= '0;
      strb_prev_q <= 1'b0;
      primed_q    <= 1'b0;
      for (int i = 0; i < C_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
      cur_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      wa_q        <= '0;
      wd_q        <= '0;
      we_q        <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      strb_prev_q <= strb_prev_d;
      primed_q    <= primed_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      cur_q       <= cur_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      we_q        <= we_d;
    end
  end

  assign VRAM_WAs_o    = wa_q;
  assign VRAM_WDs_o    = wd_q;
  assign VRAM_WE_o     = we_q;
  assign OSD_CPU_USE_o = cmd_q[15];
  assign STS_o         = {(state_q != S_IDLE) || (level_q != 3'd0), ovf_q, level_q,
                          state_q == S_WAIT, addr_q};

endmodule
